// File: rtl/riscv_cpu_pipelined_pkg.sv
// ISA constants, ALU operation encoding and pipeline-register layouts shared by the
// five-stage RV32I-subset core.
package riscv_cpu_pipelined_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        bne;
    logic        alu_src;
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] store_dat;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_dat;
  } memwb_t;

  function automatic alu_op_e alu_r_op(input logic [2:0] f3, input logic [6:0] f7);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_XOR:     op = ALU_XOR;
      F3_SRL:     op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_cpu_pipelined_alu.sv
// Combinational 32-bit ALU for the EX stage; signed slt, shifts use the low 5 bits of b.
module riscv_cpu_pipelined_alu
  import riscv_cpu_pipelined_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res
);

  always_comb begin
    o_res = '0;
    case (i_op)
      ALU_ADD: o_res = i_a + i_b;
      ALU_SUB: o_res = i_a - i_b;
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_SLT: o_res = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLL: o_res = i_a << i_b[4:0];
      ALU_SRL: o_res = i_a >> i_b[4:0];
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/riscv_cpu_pipelined_dmem.sv
// Data RAM: synchronous word write, combinational word read; contents survive reset.
module riscv_cpu_pipelined_dmem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdat,
  output logic [31:0]              o_rdat
);

  logic [31:0] memory [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) memory[i_addr] <= i_wdat;
  end

  assign o_rdat = memory[i_addr];

endmodule

// File: rtl/riscv_cpu_pipelined_imem.sv
// Instruction ROM, combinational word read; contents are loaded from outside the design.
module riscv_cpu_pipelined_imem #(
  parameter int DEPTH = 256
) (
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  output logic [31:0]              o_rdat
);

  logic [31:0] memory [0:DEPTH-1];

  assign o_rdat = memory[i_addr];

endmodule

// File: rtl/riscv_cpu_pipelined_reg_file.sv
// 32x32 register file, x0 hardwired to zero; a same-cycle write is visible on the read ports.
module riscv_cpu_pipelined_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic [31:0] o_rs1_dat,
  output logic [31:0] o_rs2_dat,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdat
);

  logic [31:0] registers [0:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && i_waddr != 5'd0) begin
      registers[i_waddr] <= i_wdat;
    end
  end

  always_comb begin
    o_rs1_dat = registers[i_rs1];
    o_rs2_dat = registers[i_rs2];
    if (i_rs1 == 5'd0) o_rs1_dat = '0;
    else if (i_we && i_waddr == i_rs1) o_rs1_dat = i_wdat;
    if (i_rs2 == 5'd0) o_rs2_dat = '0;
    else if (i_we && i_waddr == i_rs2) o_rs2_dat = i_wdat;
  end

endmodule

// File: rtl/riscv_cpu_pipelined.sv
// Five-stage in-order RV32I-subset core: branches resolve in EX (2-cycle flush), one-cycle
// load-use stall, full forwarding; a decoded halt word freezes fetch and raises end_program.
module riscv_cpu_pipelined
  import riscv_cpu_pipelined_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  output logic end_program
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] r_pc, r_ifid_instr, r_ifid_pc;
  logic        r_end;
  idex_t       r_idex, w_ctrl;
  exmem_t      r_exmem, w_exmem;
  memwb_t      r_memwb, w_memwb;

  logic [31:0] w_instr, w_rs1_dat, w_rs2_dat, w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;
  logic [31:0] w_dmem_rdat, w_br_target;
  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_use_rs1, w_use_rs2, w_stall, w_halt, w_take;

  riscv_cpu_pipelined_imem #(.DEPTH(IMEM_DEPTH)) imem (
    .i_addr (r_pc[IAW+1:2]),
    .o_rdat (w_instr)
  );

  assign w_opcode = r_ifid_instr[6:0];
  assign w_rd     = r_ifid_instr[11:7];
  assign w_f3     = r_ifid_instr[14:12];
  assign w_rs1    = r_ifid_instr[19:15];
  assign w_rs2    = r_ifid_instr[24:20];
  assign w_f7     = r_ifid_instr[31:25];

  riscv_cpu_pipelined_reg_file reg_file (
    .clk       (clk),
    .reset     (reset),
    .i_rs1     (w_rs1),
    .i_rs2     (w_rs2),
    .o_rs1_dat (w_rs1_dat),
    .o_rs2_dat (w_rs2_dat),
    .i_we      (r_memwb.reg_write),
    .i_waddr   (r_memwb.rd),
    .i_wdat    (r_memwb.wb_dat)
  );

  always_comb begin
    w_ctrl         = '0;
    w_ctrl.alu_op  = ALU_ADD;
    w_ctrl.rd      = w_rd;
    w_ctrl.rs1     = w_rs1;
    w_ctrl.rs2     = w_rs2;
    w_ctrl.rs1_val = w_rs1_dat;
    w_ctrl.rs2_val = w_rs2_dat;
    w_ctrl.pc      = r_ifid_pc;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    case (w_opcode)
      OP_R: begin
        // Only sub uses the alternate funct7; sltu and sra fall through as NOP.
        if (w_f3 != F3_SLTU && (w_f7 == F7_BASE || (w_f7 == F7_ALT && w_f3 == F3_ADD_SUB))) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_op    = alu_r_op(w_f3, w_f7);
          w_use_rs1        = 1'b1;
          w_use_rs2        = 1'b1;
        end
      end
      OP_I: begin
        if (w_f3 == F3_ADD_SUB || w_f3 == F3_AND || w_f3 == F3_OR || w_f3 == F3_SLT) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.alu_op    = alu_r_op(w_f3, F7_BASE);
          w_ctrl.imm       = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
          w_use_rs1        = 1'b1;
        end
      end
      OP_LOAD: begin
        if (w_f3 == F3_LW) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.imm       = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
          w_use_rs1        = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_f3 == F3_LW) begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.imm       = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
          w_use_rs1        = 1'b1;
          w_use_rs2        = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (w_f3 == F3_BEQ || w_f3 == F3_BNE) begin
          w_ctrl.branch = 1'b1;
          w_ctrl.bne    = (w_f3 == F3_BNE);
          w_ctrl.imm    = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                           r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
          w_use_rs1     = 1'b1;
          w_use_rs2     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_stall = r_idex.mem_read && r_idex.rd != 5'd0 &&
                   ((w_use_rs1 && r_idex.rd == w_rs1) || (w_use_rs2 && r_idex.rd == w_rs2));
  assign w_halt  = (r_ifid_instr == HALT_WORD) && !w_take;

  // EX/MEM wins over MEM/WB so the youngest producer is forwarded.
  always_comb begin
    w_fwd_a = r_idex.rs1_val;
    if (r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs1)
      w_fwd_a = r_exmem.alu_res;
    else if (r_memwb.reg_write && r_memwb.rd != 5'd0 && r_memwb.rd == r_idex.rs1)
      w_fwd_a = r_memwb.wb_dat;
    w_fwd_b = r_idex.rs2_val;
    if (r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs2)
      w_fwd_b = r_exmem.alu_res;
    else if (r_memwb.reg_write && r_memwb.rd != 5'd0 && r_memwb.rd == r_idex.rs2)
      w_fwd_b = r_memwb.wb_dat;
  end

  assign w_alu_b     = r_idex.alu_src ? r_idex.imm : w_fwd_b;
  assign w_br_target = r_idex.pc + r_idex.imm;
  assign w_take      = r_idex.branch && ((w_fwd_a == w_fwd_b) != r_idex.bne);

  riscv_cpu_pipelined_alu alu (
    .i_op  (r_idex.alu_op),
    .i_a   (w_fwd_a),
    .i_b   (w_alu_b),
    .o_res (w_alu_res)
  );

  riscv_cpu_pipelined_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
    .clk    (clk),
    .i_we   (r_exmem.mem_write),
    .i_addr (r_exmem.alu_res[DAW+1:2]),
    .i_wdat (r_exmem.store_dat),
    .o_rdat (w_dmem_rdat)
  );

  always_comb begin
    w_exmem           = '0;
    w_exmem.reg_write = r_idex.reg_write;
    w_exmem.mem_read  = r_idex.mem_read;
    w_exmem.mem_write = r_idex.mem_write;
    w_exmem.rd        = r_idex.rd;
    w_exmem.alu_res   = w_alu_res;
    w_exmem.store_dat = w_fwd_b;
    w_memwb           = '0;
    w_memwb.reg_write = r_exmem.reg_write;
    w_memwb.rd        = r_exmem.rd;
    w_memwb.wb_dat    = r_exmem.mem_read ? w_dmem_rdat : r_exmem.alu_res;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc         <= '0;
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc    <= '0;
      r_idex       <= '0;
      r_exmem      <= '0;
      r_memwb      <= '0;
      r_end        <= 1'b0;
    end else begin
      if (w_halt) r_end <= 1'b1;
      if (w_take) begin
        r_pc         <= w_br_target;
        r_ifid_instr <= NOP_WORD;
      end else if (!(w_stall || w_halt || r_end)) begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_instr <= w_instr;
        r_ifid_pc    <= r_pc;
      end
      r_idex  <= (w_take || w_stall || w_halt) ? '0 : w_ctrl;
      r_exmem <= w_exmem;
      r_memwb <= w_memwb;
    end
  end

  assign end_program = r_end;

endmodule

// File: tb/tb_riscv_cpu_pipelined.sv
// Directed-program bench: expected register writebacks are queued per program and a monitor
// compares each retiring write; end-of-run timing, register file and memory are checked directly.
module tb_riscv_cpu_pipelined;
  import riscv_cpu_pipelined_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic end_program;

  always #5 clk = ~clk;

  riscv_cpu_pipelined dut (
    .clk         (clk),
    .reset       (reset),
    .end_program (end_program)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  int          checks = 0;
  int          errors = 0;
  wb_t         exp_q[$];
  logic [31:0] prog[$];
  logic [31:0] exp_regs [0:31];
  bit          mon_en = 1'b0;

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int rs2, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int rd, input int val);
    wb_t e;
    e.rd  = 5'(rd);
    e.val = 32'(val);
    exp_q.push_back(e);
    exp_regs[rd] = 32'(val);
  endtask

  // Writeback monitor: each retiring non-x0 write must match the head of the queue.
  always @(posedge clk) begin
    wb_t e;
    #1;
    if (mon_en && reset && dut.reg_file.i_we && dut.reg_file.i_waddr != 5'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got x%0d=0x%08h expected no write",
                 dut.reg_file.i_waddr, dut.reg_file.i_wdat);
      end else begin
        e = exp_q.pop_front();
        if (e.rd !== dut.reg_file.i_waddr || e.val !== dut.reg_file.i_wdat) begin
          errors++;
          $display("FAIL wb_order: got x%0d=0x%08h expected x%0d=0x%08h",
                   dut.reg_file.i_waddr, dut.reg_file.i_wdat, e.rd, e.val);
        end
      end
    end
  end

  task automatic load_and_reset();
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = NOP_WORD;
    for (int i = 0; i < prog.size(); i++) dut.imem.memory[i] = prog[i];
    exp_q.delete();
    for (int r = 0; r < 32; r++) exp_regs[r] = '0;
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_pc"}, dut.r_pc, 32'd0);
    chk({name, "_end"}, 32'(end_program), 32'd0);
    for (int r = 0; r < 32; r++) chk($sformatf("%s_x%0d", name, r), dut.reg_file.registers[r], 32'd0);
  endtask

  task automatic run_to_end(input string name, input int exp_cycles);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    while (!done && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (end_program) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: end_program still 0 after %0d cycles expected 1", name, cyc);
    end
    chk({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    repeat (5) @(negedge clk);
    chk({name, "_wb_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_end_sticky"}, 32'(end_program), 32'd1);
    for (int r = 0; r < 32; r++)
      chk($sformatf("%s_x%0d", name, r), dut.reg_file.registers[r], exp_regs[r]);
  endtask

  task automatic countdown_prog();
    prog.delete();
    prog.push_back(enc_i(3, 0, 0, 1, 7'h13));
    prog.push_back(enc_i(7, 0, 0, 2, 7'h13));
    prog.push_back(enc_b(16, 1, 0, 0));
    prog.push_back(enc_r(0, 1, 2, 0, 2));
    prog.push_back(enc_i(-1, 1, 0, 1, 7'h13));
    prog.push_back(enc_b(-12, 0, 0, 0));
    prog.push_back(HALT_WORD);
  endtask

  task automatic countdown_exp();
    push(1, 3); push(2, 7);
    push(2, 10); push(1, 2);
    push(2, 12); push(1, 1);
    push(2, 13); push(1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("por");

    // Countdown loop: three taken back-branches then exit branch to the halt.
    countdown_prog();
    load_and_reset();
    countdown_exp();
    run_to_end("loop", 25);

    // Back-to-back dependencies resolved by forwarding, no stall.
    prog.delete();
    prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
    prog.push_back(enc_r(0, 1, 1, 0, 2));
    prog.push_back(enc_r(0, 1, 2, 0, 3));
    prog.push_back(HALT_WORD);
    load_and_reset();
    push(1, 5); push(2, 10); push(3, 15);
    run_to_end("fwd", 5);

    // Load-use: exactly one bubble, so halt is seen one cycle later than a straight run.
    prog.delete();
    prog.push_back(enc_i(42, 0, 0, 1, 7'h13));
    prog.push_back(enc_s(8, 1, 0));
    prog.push_back(enc_i(8, 0, 2, 2, 7'h03));
    prog.push_back(enc_r(0, 2, 2, 0, 3));
    prog.push_back(HALT_WORD);
    load_and_reset();
    push(1, 42); push(2, 42); push(3, 84);
    run_to_end("ldu", 7);
    chk("ldu_dmem2", dut.dmem.memory[2], 32'd42);

    // Taken branch flushes the two younger instructions.
    prog.delete();
    prog.push_back(enc_b(12, 0, 0, 0));
    prog.push_back(enc_i(1, 0, 0, 5, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 6, 7'h13));
    prog.push_back(enc_i(9, 0, 0, 7, 7'h13));
    prog.push_back(HALT_WORD);
    load_and_reset();
    push(7, 9);
    run_to_end("flush", 6);

    // Writes to x0 are dropped.
    prog.delete();
    prog.push_back(enc_i(7, 0, 0, 0, 7'h13));
    prog.push_back(enc_r(0, 0, 0, 0, 1));
    prog.push_back(HALT_WORD);
    load_and_reset();
    push(1, 0);
    run_to_end("x0", 4);

    // Reset in the middle of the countdown loop, then a full rerun.
    countdown_prog();
    load_and_reset();
    countdown_exp();
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    for (int r = 0; r < 32; r++) exp_regs[r] = '0;
    countdown_exp();
    run_to_end("rerun", 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_cpu_pipelined.md
Name: riscv_cpu_pipelined

Overview:
Five-stage in-order RV32I-subset core (IF, ID, EX, MEM, WB) with internal instruction memory, register file and data memory. Self-contained top: only clock, reset and a program-complete flag are external. Programs are preloaded into instruction memory by hierarchical access; results are inspected by hierarchical access.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (word-addressed by PC[9:2])
DMEM_DEPTH, 256, data memory depth in 32-bit words (word-addressed by byte address [9:2])

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
end_program  output  1  sticky flag: halt word decoded, fetch stopped

Behaviour:
- Required hierarchy (bench access):
  - instance imem with array memory[0:IMEM_DEPTH-1] of 32-bit words
  - instance reg_file with array registers[0:31] of 32-bit words
  - instance dmem with array memory[0:DMEM_DEPTH-1] of 32-bit words
- Reset (reset low, async):
  - PC=0; all pipeline registers hold NOP (no reg/mem write, no branch); registers[0..31]=0; end_program=0
  - imem and dmem contents are not altered by reset
- ISA:
  - R-type: add, sub, and, or, xor, slt, sll, srl
  - I-type: addi, andi, ori, slti
  - Memory: lw, sw
  - Branch: beq, bne
  - Any other encoding except the halt word executes as NOP
  - x0 always reads 0; writes to x0 are ignored
- Halt: instruction 32'hFFFFFFFF decoded in ID and not being flushed
  - end_program is set on the next edge and stays 1 until reset
  - PC and IF/ID freeze; halt word enters ID/EX as NOP
  - Older instructions drain and complete within 4 cycles
- Branches: predict not-taken, resolved in EX
  - Taken: PC <= branch PC + sign-extended B-immediate (bit0 = 0)
  - Flush IF/ID and ID/EX (2-cycle penalty); a flushed halt word is ignored
- Forwarding into EX operands, priority: EX/MEM result, then MEM/WB result, then register file
- Register file writes in WB, read in ID; same-cycle write/read of the same register returns the new value (write-through bypass)
- Load-use hazard: lw in EX with rd matching ID rs1/rs2 (rd != 0)
  - Stall PC and IF/ID one cycle; insert bubble into ID/EX; then forward from MEM/WB
- dmem write: synchronous, in MEM on sw. Read is combinational within MEM.
- imem read: combinational.
- Arithmetic: 32-bit wrap-around. slt is signed. Shift amount is the low 5 bits.
- Out-of-range addresses wrap modulo depth.

Decomposition:
- Shared package holds:
  - opcode/funct3/funct7 constants
  - ALU operation enum
  - HALT_WORD = 32'hFFFFFFFF
  - NOP encoding (addi x0,x0,0)
- Sub-modules: imem, reg_file, dmem (instance names fixed as above).
- An alu sub-module is natural. The hazard/forwarding unit stays inline in the top.

Test Plan:
- Countdown loop test
  - Program: addi x1,x0,3; addi x2,x0,7; beq x1,x0,+16; add x2,x2,x1; addi x1,x1,-1; beq x0,x0,-12; 32'hFFFFFFFF
  - Required: end_program rises; 5 cycles later x1=0, x2=13, all other regs 0
- Back-to-back dependency: addi x1,x0,5; add x2,x1,x1; add x3,x2,x1 -> x2=10, x3=15 with no stall (forwarding).
- Load-use: addi x1,x0,42; sw x1,8(x0); lw x2,8(x0); add x3,x2,x2 -> dmem.memory[2]=42, x3=84, exactly one bubble inserted.
- Branch flush:
  - Program: beq x0,x0,+12; addi x5,x0,1; addi x6,x0,1; addi x7,x0,9; halt
  - Required: x5=0, x6=0, x7=9
- x0 protection: addi x0,x0,7; add x1,x0,x0 -> registers[0]=0, x1=0.
- Reset mid-run: pull reset low during the countdown loop -> PC=0, registers cleared, end_program=0. After release the program reruns to the same final values.
